// File: rtl/result_buf_pkg.sv
// Shared widths and types for the systolic-array result buffer bank.
// A row is split into four 128 b group words, one per group FIFO.
package result_buf_pkg;

  localparam int NUM_GRP       = 4;
  localparam int LANES_PER_GRP = 4;
  localparam int LANE_W        = 32;
  localparam int GRP_W         = LANES_PER_GRP * LANE_W;
  localparam int ROW_W         = NUM_GRP * GRP_W;

  typedef logic [GRP_W-1:0] grp_word_t;

endpackage

// File: rtl/result_fifo.sv
// Single-clock show-ahead FIFO holding one group's result words.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module result_fifo
  import result_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      push,
  input  logic      pop,
  input  grp_word_t din,
  output grp_word_t dout,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  grp_word_t     mem_r [DEPTH];
  logic          do_push_s;
  logic          do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; clear and rst both flush the queue.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/result_buffer_bank.sv
// Four-group result buffer between the systolic array and the store controller.
// Rows are written all-or-nothing across enabled groups; each group drains independently.
module result_buffer_bank
  import result_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ROW_W-1:0]   wr_data,
  input  logic [NUM_GRP-1:0] wr_group_en,
  input  logic [NUM_GRP-1:0] rd_result,
  input  logic [1:0]         buffer_sel,
  output logic [GRP_W-1:0]   rd_data,
  output logic [NUM_GRP-1:0] buffer_empty,
  output logic [NUM_GRP-1:0] buffer_full,
  output logic               underflow_err
);

  logic [NUM_GRP-1:0] push_s;
  grp_word_t          head_s [NUM_GRP];
  logic               underflow_err_r;

  // A row may only go in if none of its target groups is full.
  assign wr_ready      = ~|(buffer_full & wr_group_en);
  assign push_s        = {NUM_GRP{wr_valid && wr_ready}} & wr_group_en;
  assign underflow_err = underflow_err_r;

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_fifo
    result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push_s[g]),
      .pop   (rd_result[g]),
      .din   (wr_data[g*GRP_W +: GRP_W]),
      .dout  (head_s[g]),
      .empty (buffer_empty[g]),
      .full  (buffer_full[g])
    );
  end

  // Show-ahead head of the selected group.
  always_comb begin
    rd_data = {GRP_W{1'b0}};
    case (buffer_sel)
      2'd0:    rd_data = head_s[0];
      2'd1:    rd_data = head_s[1];
      2'd2:    rd_data = head_s[2];
      2'd3:    rd_data = head_s[3];
      default: rd_data = {GRP_W{1'b0}};
    endcase
  end

  // Sticky underflow flag, dropped only by rst or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      underflow_err_r <= 1'b0;
    end else if (|(rd_result & buffer_empty)) begin
      underflow_err_r <= 1'b1;
    end else begin
      underflow_err_r <= underflow_err_r;
    end
  end

endmodule

// File: tb/tb_result_buffer_bank.sv
// Randomized and directed bench for result_buffer_bank against a queue-based model.
module tb_result_buffer_bank;

  localparam int DEPTH = 16;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         wr_valid;
  logic         wr_ready;
  logic [511:0] wr_data;
  logic [3:0]   wr_group_en;
  logic [3:0]   rd_result;
  logic [1:0]   buffer_sel;
  logic [127:0] rd_data;
  logic [3:0]   buffer_empty;
  logic [3:0]   buffer_full;
  logic         underflow_err;

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] mq [4][$];
  bit           merr;

  result_buffer_bank #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_group_en   (wr_group_en),
    .rd_result     (rd_result),
    .buffer_sel    (buffer_sel),
    .rd_data       (rd_data),
    .buffer_empty  (buffer_empty),
    .buffer_full   (buffer_full),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    for (int g = 0; g < 4; g++)
      if (wr_group_en[g] && mq[g].size() == DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int g = 0; g < 4; g++) e[g] = (mq[g].size() == 0);
    return e;
  endfunction

  function automatic logic [3:0] model_full();
    logic [3:0] f;
    for (int g = 0; g < 4; g++) f[g] = (mq[g].size() == DEPTH);
    return f;
  endfunction

  task automatic check_outputs();
    chk("wr_ready", 128'(wr_ready), 128'(model_ready()));
    chk("buffer_empty", 128'(buffer_empty), 128'(model_empty()));
    chk("buffer_full", 128'(buffer_full), 128'(model_full()));
    chk("underflow_err", 128'(underflow_err), 128'(merr));
    if (mq[buffer_sel].size() > 0) chk("rd_data", rd_data, mq[buffer_sel][0]);
  endtask

  task automatic model_update();
    bit rdy;
    rdy = model_ready();
    if (rst || clear) begin
      for (int g = 0; g < 4; g++) mq[g].delete();
      merr = 1'b0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        if (rd_result[g]) begin
          if (mq[g].size() > 0) void'(mq[g].pop_front());
          else merr = 1'b1;
        end
      end
      if (wr_valid && rdy)
        for (int g = 0; g < 4; g++)
          if (wr_group_en[g]) mq[g].push_back(wr_data[g*128 +: 128]);
    end
  endtask

  // Inputs are set at posedge+1; check and model-step at the following negedge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_row();
    for (int l = 0; l < 16; l++) wr_data[l*32 +: 32] = $urandom;
  endtask

  task automatic idle();
    rst = 1'b0; clear = 1'b0; wr_valid = 1'b0; rd_result = 4'b0000;
  endtask

  initial begin
    merr = 1'b0;
    rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0;
    wr_group_en = 4'b0000; rd_result = 4'b0000; buffer_sel = 2'd0;
    tick();
    tick();
    idle();
    wr_group_en = 4'b1111;
    #1;
    chk("rst_empty", 128'(buffer_empty), 128'(4'b1111));
    chk("rst_full", 128'(buffer_full), 128'(4'b0000));
    chk("rst_err", 128'(underflow_err), 128'(1'b0));
    chk("rst_ready", 128'(wr_ready), 128'(1'b1));

    // Lane-index row across all groups
    for (int l = 0; l < 16; l++) wr_data[l*32 +: 32] = 32'(l);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0; buffer_sel = 2'd2;
    #1;
    chk("row_empty", 128'(buffer_empty), 128'(4'b0000));
    chk("row_grp2", rd_data, {32'd11, 32'd10, 32'd9, 32'd8});
    clear = 1'b1;
    tick();
    idle();

    // Fill groups 0 and 1
    wr_group_en = 4'b0011;
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_row();
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("fill_full", 128'(buffer_full), 128'(4'b0011));
    chk("fill_ready0", 128'(wr_ready), 128'(1'b0));
    wr_group_en = 4'b0100;
    #1;
    chk("fill_ready_g2", 128'(wr_ready), 128'(1'b1));

    // Push blocked on full group 0 while popping it
    wr_group_en = 4'b0001; wr_valid = 1'b1; rd_result = 4'b0001; buffer_sel = 2'd0;
    rand_row();
    #1;
    chk("full_pop_ready", 128'(wr_ready), 128'(1'b0));
    tick();
    wr_valid = 1'b0; rd_result = 4'b0000;
    #1;
    chk("after_pop_ready", 128'(wr_ready), 128'(1'b1));
    chk("after_pop_full", 128'(buffer_full[0]), 128'(1'b0));
    chk("occ15", 128'(mq[0].size()), 128'(15));
    clear = 1'b1;
    tick();
    idle();

    // Underflow on empty group 3 is sticky until clear
    rd_result = 4'b1000;
    tick();
    rd_result = 4'b0000;
    #1;
    chk("uflow_set", 128'(underflow_err), 128'(1'b1));
    chk("uflow_empty", 128'(buffer_empty), 128'(4'b1111));
    tick();
    chk("uflow_held", 128'(underflow_err), 128'(1'b1));
    clear = 1'b1;
    tick();
    idle();
    chk("clear_err", 128'(underflow_err), 128'(1'b0));
    chk("clear_empty", 128'(buffer_empty), 128'(4'b1111));

    // Streaming through group 1 across pointer wrap
    wr_group_en = 4'b0010; buffer_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      rand_row();
      wr_valid = 1'b1;
      rd_result = (i > 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    wr_valid = 1'b0; rd_result = 4'b0010;
    tick();
    rd_result = 4'b0000;
    #1;
    chk("wrap_drained", 128'(buffer_empty[1]), 128'(1'b1));

    // rst mid-transfer discards group 0 contents
    wr_group_en = 4'b0001; wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_row();
      tick();
    end
    wr_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_empty", 128'(buffer_empty[0]), 128'(1'b1));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      clear       = ($urandom_range(0, 99) == 0);
      wr_valid    = ($urandom_range(0, 3) != 0);
      wr_group_en = 4'($urandom);
      rd_result   = 4'($urandom) & 4'($urandom) & 4'($urandom);
      buffer_sel  = 2'($urandom);
      rand_row();
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
